multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the 64-bit RISC-V datapath: pc, instruction/data memory, register file, immediate generator, ALU control and ALU.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives all datapath enables, and waits on a memory-ready handshake.
- Replaces the single-cycle main control unit.
- Supported classes: R-type (0110011), I-ALU (0010011), ld (0000011), sd (0100011), beq (1100011), SYSTEM (1110011, halt).

---
 rtl/riscv_ctrl_pkg.sv | 63 ++++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer.
//   - Opcode constants for the supported instruction classes
//   - ALU operation encodings driven on aluop
//   - Sequencer state encodings (also visible on state_dbg)
//   - Instruction-class encoding latched in DECODE, plus decode and
//     ALU-control helper functions
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_IALU    = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_SYSTEM  = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  function automatic instr_class_t decode_class(input logic [6:0] op);
    case (op)
      OP_RTYPE:  return CLS_RTYPE;
      OP_IALU:   return CLS_IALU;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_SYSTEM: return CLS_SYSTEM;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

  // Returns {alusrc, aluop[1:0]} for a class; held from EXEC through WB.
  function automatic logic [2:0] alu_ctrl(input instr_class_t cls);
    case (cls)
      CLS_RTYPE:           return {1'b0, ALUOP_FUNCT};
      CLS_IALU:            return {1'b1, ALUOP_FUNCT};
      CLS_LOAD, CLS_STORE: return {1'b1, ALUOP_ADD};
      CLS_BRANCH:          return {1'b0, ALUOP_SUB};
      default:             return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory handshakes.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clear   : restart the count from zero (entry into a waiting state)
//   enable  : count one more idle cycle
//   timeout : count has reached TIMEOUT_CYCLES-1
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;

  // Count stops at LIMIT so it can never wrap back below the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 64-bit RISC-V datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables; HALT (SYSTEM) and FAULT (bad opcode / memory timeout)
// are sticky until reset.
//   clk, reset          : clock and asynchronous active-high reset
//   start               : leave IDLE
//   opcode              : instruction[6:0], sampled in DECODE only
//   zero                : ALU zero flag for beq
//   mem_ready           : memory finished the current request
//   instr_req, ir_write : instruction fetch request / IR load
//   pc_write, pc_src    : pc update and source select (1 = branch target)
//   regwrite, memtoreg  : register writeback enable / select memory data
//   memread, memwrite   : data memory request
//   alusrc, aluop       : ALU operand-B select and operation class
//   busy, halted, fault : status
//   state_dbg           : current state encoding
//   instr_count         : retired instruction count (wraps)
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        instr_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state_dbg,
  output logic [31:0] instr_count
);

  logic [2:0]   state_q;
  logic [2:0]   state_d;
  instr_class_t cls_q;
  instr_class_t dec_cls;
  logic         tmo;
  logic         wait_clear;
  logic         wait_en;

  assign dec_cls = decode_class(opcode);

  // The wait count restarts only when a waiting state is newly entered,
  // not while it is being held.
  assign wait_clear = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                      ((state_d == ST_MEM)   && (state_q != ST_MEM));
  assign wait_en    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (reset),
    .clear  (wait_clear),
    .enable (wait_en),
    .timeout(tmo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Class is captured once in DECODE; opcode is don't-care afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_q <= CLS_NONE;
    end else if (state_q == ST_DECODE) begin
      cls_q <= dec_cls;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 32'd0;
    end else if (pc_write) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  // mem_ready is tested before the timeout so a late completion wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)  state_d = ST_DECODE;
        else if (tmo)   state_d = ST_FAULT;
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_SYSTEM:  state_d = ST_HALT;
          CLS_ILLEGAL: state_d = ST_FAULT;
          default:     state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH:          state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)  state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (tmo)   state_d = ST_FAULT;
      end
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    instr_req = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    regwrite  = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    alusrc    = 1'b0;
    aluop     = ALUOP_ADD;
    busy      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        busy      = 1'b1;
        instr_req = 1'b1;
        ir_write  = mem_ready;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXEC: begin
        busy            = 1'b1;
        {alusrc, aluop} = alu_ctrl(cls_q);
        if (cls_q == CLS_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = zero;
        end
      end
      ST_MEM: begin
        busy     = 1'b1;
        alusrc   = 1'b1;
        aluop    = ALUOP_ADD;
        memread  = (cls_q == CLS_LOAD);
        memwrite = (cls_q == CLS_STORE);
        pc_write = mem_ready && (cls_q == CLS_STORE);
      end
      ST_WB: begin
        busy            = 1'b1;
        {alusrc, aluop} = alu_ctrl(cls_q);
        regwrite        = 1'b1;
        memtoreg        = (cls_q == CLS_LOAD);
        pc_write        = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (TIMEOUT_CYCLES = 4).
module tb_multicycle_control_fsm;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        instr_req, ir_write, pc_write, pc_src, regwrite;
  logic        memread, memwrite, memtoreg, alusrc;
  logic [1:0]  aluop;
  logic        busy, halted, fault;
  logic [2:0]  state_dbg;
  logic [31:0] instr_count;

  int n_cmp  = 0;
  int n_fail = 0;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .instr_req  (instr_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .regwrite   (regwrite),
    .memread    (memread),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .alusrc     (alusrc),
    .aluop      (aluop),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .state_dbg  (state_dbg),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  wire [13:0] all_outs = {instr_req, ir_write, pc_write, pc_src, regwrite, memread,
                          memwrite, memtoreg, alusrc, aluop, busy, halted, fault};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hard_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_cmp++; if (all_outs !== 14'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs); end
    n_cmp++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    reset = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state_dbg); end
    launch();
    #1;
    n_cmp++; if ({state_dbg, busy} !== {ST_FETCH, 1'b1}) begin n_fail++; $display("FAIL start_fetch: got st=%0d busy=%0b want st=1 busy=1", state_dbg, busy); end
  endtask

  task automatic test_rtype();
    int exp_st [4];
    int pcw;
    exp_st = '{1, 2, 3, 5};
    pcw = 0;
    hard_reset();
    opcode = OP_RTYPE; mem_ready = 1'b1;
    launch();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (state_dbg !== 3'(exp_st[c])) begin n_fail++; $display("FAIL rtype_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]); end
      n_cmp++; if (regwrite !== (c == 3)) begin n_fail++; $display("FAIL rtype_regwrite c%0d: got %0b want %0b", c, regwrite, (c == 3)); end
      if (c == 0) begin
        n_cmp++; if ({instr_req, ir_write} !== 2'b11) begin n_fail++; $display("FAIL rtype_fetch: got %b want 11", {instr_req, ir_write}); end
      end
      if (c == 3) begin
        n_cmp++; if ({alusrc, aluop, memtoreg} !== 4'b0100) begin n_fail++; $display("FAIL rtype_wb_alu: got %b want 0100", {alusrc, aluop, memtoreg}); end
      end
      if (pc_write) pcw++;
      tick();
    end
    #1;
    n_cmp++; if (state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL rtype_return: got %0d want 1", state_dbg); end
    n_cmp++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL rtype_count: got %0d want 1", instr_count); end
    n_cmp++; if (pcw !== 1) begin n_fail++; $display("FAIL rtype_pcwrites: got %0d want 1", pcw); end
  endtask

  task automatic test_ld();
    logic mr [8];
    int   exp_st [8];
    int   pcw;
    int   rd_cycles;
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_st = '{1, 2, 3, 4, 4, 4, 4, 5};
    pcw = 0; rd_cycles = 0;
    hard_reset();
    opcode = OP_LOAD;
    launch();
    for (int c = 0; c < 8; c++) begin
      mem_ready = mr[c];
      if (c == 3) opcode = 7'h7f;
      #1;
      n_cmp++; if (state_dbg !== 3'(exp_st[c])) begin n_fail++; $display("FAIL ld_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]); end
      if (c == 2) begin
        n_cmp++; if ({alusrc, aluop} !== 3'b100) begin n_fail++; $display("FAIL ld_exec_alu: got %b want 100", {alusrc, aluop}); end
      end
      if (exp_st[c] == 4) begin
        n_cmp++; if ({memread, memwrite, alusrc, aluop} !== 5'b10100) begin n_fail++; $display("FAIL ld_mem c%0d: got %b want 10100", c, {memread, memwrite, alusrc, aluop}); end
      end
      if (c == 7) begin
        n_cmp++; if ({regwrite, memtoreg, pc_write, pc_src} !== 4'b1110) begin n_fail++; $display("FAIL ld_wb: got %b want 1110", {regwrite, memtoreg, pc_write, pc_src}); end
      end
      if (pc_write) pcw++;
      if (memread) rd_cycles++;
      tick();
    end
    #1;
    n_cmp++; if (state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL ld_return: got %0d want 1", state_dbg); end
    n_cmp++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL ld_count: got %0d want 1", instr_count); end
    n_cmp++; if (pcw !== 1) begin n_fail++; $display("FAIL ld_pcwrites: got %0d want 1", pcw); end
    n_cmp++; if (rd_cycles !== 4) begin n_fail++; $display("FAIL ld_memread_cycles: got %0d want 4", rd_cycles); end
  endtask

  task automatic test_beq();
    int exp_st [3];
    exp_st = '{1, 2, 3};
    hard_reset();
    opcode = OP_BRANCH; mem_ready = 1'b1;
    launch();
    for (int it = 0; it < 2; it++) begin
      zero = (it == 0);
      for (int c = 0; c < 3; c++) begin
        #1;
        n_cmp++; if (state_dbg !== 3'(exp_st[c])) begin n_fail++; $display("FAIL beq_state it%0d c%0d: got %0d want %0d", it, c, state_dbg, exp_st[c]); end
        if (c == 2) begin
          n_cmp++; if ({pc_write, pc_src, alusrc, aluop} !== {1'b1, (it == 0), 1'b0, 2'b01}) begin n_fail++; $display("FAIL beq_exec it%0d: got %b want %b", it, {pc_write, pc_src, alusrc, aluop}, {1'b1, (it == 0), 1'b0, 2'b01}); end
        end else begin
          n_cmp++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL beq_pcw it%0d c%0d: got %0b want 0", it, c, pc_write); end
        end
        tick();
      end
      #1;
      n_cmp++; if ({state_dbg, instr_count} !== {ST_FETCH, 32'(it + 1)}) begin n_fail++; $display("FAIL beq_retire it%0d: got st=%0d cnt=%0d want st=1 cnt=%0d", it, state_dbg, instr_count, it + 1); end
    end
    zero = 1'b0;
  endtask

  task automatic test_timeout();
    hard_reset();
    opcode = OP_RTYPE; mem_ready = 1'b0;
    launch();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if ({state_dbg, fault} !== {ST_FETCH, 1'b0}) begin n_fail++; $display("FAIL tmo_wait c%0d: got st=%0d fault=%0b want st=1 fault=0", c, state_dbg, fault); end
      tick();
    end
    #1;
    n_cmp++; if ({state_dbg, fault, busy, instr_req} !== {ST_FAULT, 3'b100}) begin n_fail++; $display("FAIL tmo_fault: got st=%0d f=%0b b=%0b req=%0b want st=7 f=1 b=0 req=0", state_dbg, fault, busy, instr_req); end
    start = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    start = 1'b0;
    #1;
    n_cmp++; if ({state_dbg, fault} !== {ST_FAULT, 1'b1}) begin n_fail++; $display("FAIL tmo_sticky: got st=%0d f=%0b want st=7 f=1", state_dbg, fault); end
    hard_reset();
    launch();
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      #1;
      n_cmp++; if ({state_dbg, ir_write, fault} !== {ST_FETCH, (c == 3), 1'b0}) begin n_fail++; $display("FAIL tmo_late_ready c%0d: got st=%0d irw=%0b f=%0b want st=1 irw=%0b f=0", c, state_dbg, ir_write, fault, (c == 3)); end
      tick();
    end
    #1;
    n_cmp++; if ({state_dbg, fault} !== {ST_DECODE, 1'b0}) begin n_fail++; $display("FAIL tmo_late_decode: got st=%0d f=%0b want st=2 f=0", state_dbg, fault); end
  endtask

  task automatic test_halt_fault();
    int pcw;
    pcw = 0;
    hard_reset();
    opcode = OP_SYSTEM; mem_ready = 1'b1;
    launch();
    for (int c = 0; c < 2; c++) begin
      #1;
      if (pc_write) pcw++;
      tick();
    end
    start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (pc_write) pcw++;
      tick();
    end
    start = 1'b0;
    #1;
    n_cmp++; if ({state_dbg, halted, busy, fault} !== {ST_HALT, 3'b100}) begin n_fail++; $display("FAIL halt_state: got st=%0d h=%0b b=%0b f=%0b want st=6 h=1 b=0 f=0", state_dbg, halted, busy, fault); end
    n_cmp++; if (pcw !== 0) begin n_fail++; $display("FAIL halt_pcwrites: got %0d want 0", pcw); end
    n_cmp++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL halt_count: got %0d want 0", instr_count); end
    hard_reset();
    opcode = 7'b1111111; mem_ready = 1'b1;
    launch();
    tick();
    tick();
    #1;
    n_cmp++; if ({state_dbg, fault, halted, pc_write} !== {ST_FAULT, 3'b100}) begin n_fail++; $display("FAIL badop_fault: got st=%0d f=%0b h=%0b pcw=%0b want st=7 f=1 h=0 pcw=0", state_dbg, fault, halted, pc_write); end
  endtask

  task automatic test_back_to_back_reset();
    int exp_st [4];
    exp_st = '{1, 2, 3, 4};
    hard_reset();
    opcode = OP_STORE; mem_ready = 1'b1;
    launch();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (state_dbg !== 3'(exp_st[c])) begin n_fail++; $display("FAIL sd_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]); end
      if (c == 3) begin
        n_cmp++; if ({memwrite, memread, pc_write, pc_src, regwrite} !== 5'b10100) begin n_fail++; $display("FAIL sd_mem: got %b want 10100", {memwrite, memread, pc_write, pc_src, regwrite}); end
      end else begin
        n_cmp++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL sd_pcw c%0d: got %0b want 0", c, pc_write); end
      end
      tick();
    end
    #1;
    n_cmp++; if ({state_dbg, instr_count} !== {ST_FETCH, 32'd1}) begin n_fail++; $display("FAIL sd_retire: got st=%0d cnt=%0d want st=1 cnt=1", state_dbg, instr_count); end
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++; if ({state_dbg, memwrite} !== {ST_MEM, 1'b1}) begin n_fail++; $display("FAIL sd_stall: got st=%0d mw=%0b want st=4 mw=1", state_dbg, memwrite); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({state_dbg, memwrite, all_outs} !== {ST_IDLE, 15'd0}) begin n_fail++; $display("FAIL async_reset: got st=%0d mw=%0b outs=%h want st=0 mw=0 outs=0", state_dbg, memwrite, all_outs); end
    n_cmp++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", instr_count); end
    reset = 1'b0;
    tick();
    launch();
    #1;
    n_cmp++; if ({state_dbg, instr_req} !== {ST_FETCH, 1'b1}) begin n_fail++; $display("FAIL restart: got st=%0d req=%0b want st=1 req=1", state_dbg, instr_req); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    reset = 1'b1;
    test_reset();
    test_rtype();
    test_ld();
    test_beq();
    test_timeout();
    test_halt_fault();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
